// File: rtl/product_bcd_module.sv
// Signed product to sign + packed BCD magnitude converter (sequential double-dabble).
// Advances one step per clock while start_sig is held; done_sig pulses once per conversion.
module product_bcd_module #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_sig,
    input  logic [IN_W-1:0]       product,
    output logic                  done_sig,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;

    localparam logic [2:0] ST_CAPTURE = 3'd0;
    localparam logic [2:0] ST_CONVERT = 3'd1;
    localparam logic [2:0] ST_PUBLISH = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;

    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [BW-1:0]    acc_q,  acc_d;
    logic [IN_W-1:0]  mag_q,  mag_d;
    logic             neg_q,  neg_d;
    logic             done_q, done_d;
    logic             sign_q, sign_d;
    logic [BW-1:0]    bcd_q,  bcd_d;
    logic [BW-1:0]    acc_adj;

    // Each digit is 0..9, so +3 on a digit >= 5 never overflows into its neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                        (acc_q[4*gi +: 4] + 4'd3) : acc_q[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= ST_CAPTURE;
            cnt_q  <= '0;
            acc_q  <= '0;
            mag_q  <= '0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
            sign_q <= 1'b0;
            bcd_q  <= '0;
        end else begin
            step_q <= step_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            mag_q  <= mag_d;
            neg_q  <= neg_d;
            done_q <= done_d;
            sign_q <= sign_d;
            bcd_q  <= bcd_d;
        end
    end

    // A low start_sig leaves every register at its current value, pausing the conversion.
    always_comb begin
        step_d = step_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        mag_d  = mag_q;
        neg_d  = neg_q;
        done_d = done_q;
        sign_d = sign_q;
        bcd_d  = bcd_q;
        if (start_sig) begin
            case (step_q)
                ST_CAPTURE: begin
                    neg_d  = product[IN_W-1];
                    mag_d  = product[IN_W-1] ? (~product + IN_W'(1)) : product;
                    acc_d  = '0;
                    cnt_d  = '0;
                    step_d = ST_CONVERT;
                end
                ST_CONVERT: begin
                    {acc_d, mag_d} = {acc_adj, mag_q} << 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(IN_W - 1)) begin
                        step_d = ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    bcd_d  = acc_q;
                    sign_d = neg_q & (acc_q != '0);
                    done_d = 1'b1;
                    step_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    done_d = 1'b0;
                    step_d = ST_CAPTURE;
                end
                default: begin
                    step_d = ST_CAPTURE;
                end
            endcase
        end
    end

    always_comb begin
        done_sig = done_q;
        sign     = sign_q;
        bcd      = bcd_q;
    end

endmodule

// File: tb/tb_product_bcd_module.sv
// Directed-vector bench for product_bcd_module: latency, pulse width, pause and reset abort.
module tb_product_bcd_module;

    logic        clk;
    logic        rst_n;
    logic        start_sig;
    logic [15:0] product;
    logic        done_sig;
    logic        sign;
    logic [19:0] bcd;

    int checks;
    int failures;

    product_bcd_module #(
        .IN_W   (16),
        .DIGITS (5),
        .CNT_W  (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_sig (start_sig),
        .product   (product),
        .done_sig  (done_sig),
        .sign      (sign),
        .bcd       (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Runs one conversion with start held, optionally pausing after active edge pause_at.
    task automatic convert(input string tag, input logic [15:0] p, input int pause_at,
                           input int pause_len, input logic [19:0] exp_bcd, input logic exp_sign);
        int active;
        int abs_e;
        int done_at;
        int done_abs;
        logic pause_done;
        logic [19:0] held_bcd;
        logic        held_sign;
        @(negedge clk);
        product   = p;
        start_sig = 1'b1;
        active    = 0;
        abs_e     = 0;
        done_at   = -1;
        done_abs  = -1;
        pause_done = 1'b0;
        while (done_at < 0 && abs_e < 80) begin
            @(posedge clk);
            #1;
            abs_e++;
            active++;
            if (done_sig) begin
                done_at  = active;
                done_abs = abs_e;
            end else if (pause_at > 0 && active == pause_at) begin
                start_sig = 1'b0;
                product   = ~p;
                for (int k = 0; k < pause_len; k++) begin
                    @(posedge clk);
                    #1;
                    abs_e++;
                    if (done_sig) pause_done = 1'b1;
                end
                start_sig = 1'b1;
            end
        end
        if (pause_at > 0) check_val({tag, "_no_done_in_pause"}, 32'(pause_done), 32'd0);
        check_val({tag, "_done_edge"}, done_at, 18);
        check_val({tag, "_done_abs_edge"}, done_abs, 18 + pause_len);
        check_val({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        check_val({tag, "_sign"}, 32'(sign), 32'(exp_sign));
        // Caller registers its drop on the edge that ends the done cycle.
        @(posedge clk);
        #1;
        check_val({tag, "_done_width"}, 32'(done_sig), 32'd0);
        start_sig = 1'b0;
        held_bcd  = bcd;
        held_sign = sign;
        product   = 16'hA5A5;
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_bcd_hold"}, 32'(bcd), 32'(exp_bcd));
        check_val({tag, "_sign_hold"}, 32'(sign), 32'(held_sign));
        check_val({tag, "_done_stays_low"}, 32'(done_sig), 32'd0);
        if (held_bcd !== exp_bcd) check_val({tag, "_bcd_after_width"}, 32'(held_bcd), 32'(exp_bcd));
    endtask

    initial begin
        int m;
        logic [15:0] p;
        logic seen_done;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start_sig = 1'b0;
        product   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_done", 32'(done_sig), 32'd0);
        check_val("reset_sign", 32'(sign), 32'd0);
        check_val("reset_bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        convert("zero",  16'h0000, 0, 0, 20'h00000, 1'b0);
        convert("p12345", 16'h3039, 0, 0, 20'h12345, 1'b0);
        convert("m1",    16'hFFFF, 0, 0, 20'h00001, 1'b1);
        convert("m32768", 16'h8000, 0, 0, 20'h32768, 1'b1);

        m = -128 * -128;
        p = m[15:0];
        convert("mul_n128_n128", p, 0, 0, 20'h16384, 1'b0);
        m = 127 * -1;
        p = m[15:0];
        convert("mul_127_n1", p, 0, 0, 20'h00127, 1'b1);

        convert("pause9999", 16'h270F, 8, 5, 20'h09999, 1'b0);

        // Abort a conversion after its 10th edge; outputs must clear at once.
        @(negedge clk);
        product   = 16'h1234;
        start_sig = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_bcd", 32'(bcd), 32'd0);
        check_val("rst_mid_sign", 32'(sign), 32'd0);
        check_val("rst_mid_done", 32'(done_sig), 32'd0);
        start_sig = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done_sig) seen_done = 1'b1;
        end
        check_val("rst_mid_no_done", 32'(seen_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        convert("after_rst_100", 16'h0064, 0, 0, 20'h00100, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
